// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
//   Shared definitions for the configuration-chain loader:
//   - CFG_BYTE_W : width of one bitstream byte
//   - state_t    : loader FSM states (IDLE, LOAD, DONE)
//   - total_bits : number of chain stages for a given tile geometry
//   - nbytes     : bytes needed to carry a given number of bits
package ccff_loader_pkg;

    localparam int CFG_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int total_bits(input int chain_len, input int num_tiles);
        return chain_len * num_tiles;
    endfunction

    function automatic int nbytes(input int total);
        return (total + CFG_BYTE_W - 1) / CFG_BYTE_W;
    endfunction

endpackage

// File: rtl/ccff_byte_serializer.sv
// ccff_byte_serializer
//   Byte buffer and LSB-first serializer feeding the head of the config chain.
//   Holds one byte, presents one bit per cycle on registered ccff_head with a
//   registered shift_en, truncates the final byte to the bits the chain needs,
//   and raises cfg_ready so the next byte lands exactly as the last bit leaves.
// Ports:
//   prog_clk   in   programming clock
//   pReset     in   asynchronous active-low reset
//   active     in   loader is in LOAD
//   flush      in   drop buffered bits and the byte count (abort)
//   cfg_data   in   bitstream byte
//   cfg_valid  in   cfg_data valid
//   cfg_ready  out  byte accepted when cfg_valid && cfg_ready (state-only)
//   ccff_head  out  serial bit into the chain head
//   shift_en   out  chain shifts on the edge ending a cycle where this is 1
module ccff_byte_serializer
    import ccff_loader_pkg::*;
#(
    parameter int TOTAL = 585
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  active,
    input  logic                  flush,
    input  logic [CFG_BYTE_W-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  ccff_head,
    output logic                  shift_en
);

    localparam int NB        = nbytes(TOTAL);
    localparam int LAST_BITS = TOTAL - (NB - 1) * CFG_BYTE_W;
    localparam int AW        = $clog2(NB + 1);
    localparam int RW        = $clog2(CFG_BYTE_W);

    localparam logic [AW-1:0] NB_CNT   = AW'(NB);
    localparam logic [AW-1:0] LAST_IDX = AW'(NB - 1);
    localparam logic [RW-1:0] FULL_REM = RW'(CFG_BYTE_W - 1);
    localparam logic [RW-1:0] LAST_REM = RW'(LAST_BITS - 1);

    // Bits still waiting behind the one currently on ccff_head.
    logic [RW-1:0]         remain;
    logic [AW-1:0]         accepted;
    logic [CFG_BYTE_W-2:0] shreg;
    logic                  take;

    // remain == 0 covers both "buffer empty" (shift_en = 0) and "the last
    // valid bit is on the head this cycle" (shift_en = 1), so a new byte can
    // be taken back-to-back without a bubble.
    assign cfg_ready = active && (remain == '0) && (accepted < NB_CNT);
    assign take      = cfg_valid && cfg_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            remain    <= '0;
            accepted  <= '0;
            ccff_head <= 1'b0;
            shift_en  <= 1'b0;
        end else if (!active || flush) begin
            remain   <= '0;
            accepted <= '0;
            shift_en <= 1'b0;
        end else if (take) begin
            ccff_head <= cfg_data[0];
            remain    <= (accepted == LAST_IDX) ? LAST_REM : FULL_REM;
            accepted  <= accepted + AW'(1);
            shift_en  <= 1'b1;
        end else if (remain != '0) begin
            ccff_head <= shreg[0];
            remain    <= remain - RW'(1);
            shift_en  <= 1'b1;
        end else begin
            // Starved: head holds its last value and the chain stays put.
            shift_en <= 1'b0;
        end
    end

    // NOTE: the shift register is pure datapath and is only read while
    // remain != 0, which implies a byte was loaded, so it carries no reset.
    always_ff @(posedge prog_clk) begin
        if (take) begin
            shreg <= cfg_data[CFG_BYTE_W-1:1];
        end else if (remain != '0) begin
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// ccff_loader
//   Configuration-chain loader for the CLB fabric. Accepts the bitstream as a
//   valid/ready byte stream and shifts it LSB-first into the tile chain
//   (NUM_TILES x CHAIN_LEN stages), generating the enable for the gated
//   prog_clk. Holds the FSM and the remaining-bit counter; the byte buffer
//   lives in ccff_byte_serializer.
// Optional feature: define CCFF_LOADER_READBACK_EN to add rb_ones, a count of
//   ones seen on ccff_tail while the chain shifts (popcount of the previous
//   configuration). Without it ccff_tail is ignored.
// Ports:
//   prog_clk     in   programming clock, rising edge
//   pReset       in   asynchronous active-low reset
//   start        in   pulse; begins a load when idle
//   abort        in   pulse; cancels a load in progress
//   cfg_data     in   bitstream byte, bit 0 first
//   cfg_valid    in   cfg_data valid
//   cfg_ready    out  byte accepted when cfg_valid && cfg_ready
//   ccff_head    out  serial bit into chain head (registered)
//   prog_clk_en  out  chain clock-gate enable (registered)
//   ccff_tail    in   chain tail, readback only
//   busy         out  load in progress (start+1 through DONE)
//   done         out  one-cycle pulse after the final bit shifted
//   rb_ones      out  readback ones count (CCFF_LOADER_READBACK_EN only)
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 65,
    parameter int NUM_TILES = 9
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CFG_BYTE_W-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  ccff_head,
    output logic                  prog_clk_en,
    input  logic                  ccff_tail,
    output logic                  busy,
    output logic                  done
`ifdef CCFF_LOADER_READBACK_EN
    ,
    output logic [$clog2(total_bits(CHAIN_LEN, NUM_TILES) + 1)-1:0] rb_ones
`endif
);

    localparam int TOTAL = total_bits(CHAIN_LEN, NUM_TILES);
    localparam int BW    = $clog2(TOTAL + 1);

    localparam logic [BW-1:0] TOTAL_CNT = BW'(TOTAL);
    localparam logic [BW-1:0] ONE       = BW'(1);

    state_t        state;
    logic [BW-1:0] bit_cnt;
    logic          in_load;

    assign in_load = (state == LOAD);

    ccff_byte_serializer #(
        .TOTAL (TOTAL)
    ) u_serializer (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .active    (in_load),
        .flush     (abort),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .ccff_head (ccff_head),
        .shift_en  (prog_clk_en)
    );

    // bit_cnt counts chain shifts still owed; a shift happens on every cycle
    // with prog_clk_en = 1, so the FSM follows the registered enable.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // start takes priority over a simultaneous abort here.
                    if (start) begin
                        state   <= LOAD;
                        bit_cnt <= TOTAL_CNT;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (prog_clk_en) begin
                        bit_cnt <= bit_cnt - ONE;
                        if (bit_cnt == ONE) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CCFF_LOADER_READBACK_EN
    // The tail bit leaving the chain on each shift is the old configuration.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            rb_ones <= '0;
        end else if (state == IDLE && start) begin
            rb_ones <= '0;
        end else if (prog_clk_en && ccff_tail) begin
            rb_ones <= rb_ones + ONE;
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader
//   Directed self-checking bench for ccff_loader (default 65 x 9 = 585 bits,
//   74 bytes). Expected values are hand-derived; the head bit sequence is
//   checked against the byte stream the bench itself sends.
//   Define CCFF_LOADER_READBACK_EN to also exercise rb_ones with a model chain.
module tb_ccff_loader;

    localparam int TOTAL  = 585;
    localparam int NB     = 74;
    localparam int BUDGET = 3000;

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic       start;
    logic       abort;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       ccff_head;
    logic       prog_clk_en;
    logic       ccff_tail;
    logic       busy;
    logic       done;
`ifdef CCFF_LOADER_READBACK_EN
    logic [9:0] rb_ones;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] stream [NB];

    int res_shifts, res_hs, res_head_err, res_gap;
    int res_first_en, res_first_rdy, res_done_at, res_busy_err;

    always #5 prog_clk = ~prog_clk;

    ccff_loader dut (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .start       (start),
        .abort       (abort),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .ccff_head   (ccff_head),
        .prog_clk_en (prog_clk_en),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done)
`ifdef CCFF_LOADER_READBACK_EN
        ,
        .rb_ones     (rb_ones)
`endif
    );

`ifdef CCFF_LOADER_READBACK_EN
    // Model of the tile chain: shifts on the gated clock, tail is the last stage.
    logic [TOTAL-1:0] chain;
    always @(posedge prog_clk or negedge pReset) begin
        if (!pReset) chain <= '0;
        else if (prog_clk_en) chain <= {chain[TOTAL-2:0], ccff_head};
    end
    assign ccff_tail = chain[TOTAL-1];
`else
    assign ccff_tail = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    function automatic logic exp_bit(input int s);
        logic [7:0] b;
        b = stream[s / 8];
        return b[s % 8];
    endfunction

    // Runs one load from the idle cycle (cyc 0, start asserted) until done is
    // seen, the budget runs out, or stop_at shifts have been observed.
    // gap: ready cycles withheld after each byte; extra: keep offering bytes
    // beyond NB; restart_at: cycle of a stray start pulse (-1 none).
    task automatic do_load(input int gap, input bit extra, input int restart_at,
                           input bit abort_with_start, input int stop_at);
        int withheld = 0;
        res_shifts = 0; res_hs = 0; res_head_err = 0; res_gap = 0;
        res_first_en = -1; res_first_rdy = -1; res_done_at = -1; res_busy_err = 0;
        for (int cyc = 0; cyc < BUDGET && res_done_at < 0; cyc++) begin
            if (prog_clk_en === 1'b1) begin
                if (res_first_en < 0) res_first_en = cyc;
                if (ccff_head !== exp_bit(res_shifts)) res_head_err++;
                res_shifts++;
            end else if (res_shifts > 0 && res_shifts < TOTAL) begin
                res_gap++;
            end
            if (cfg_ready === 1'b1 && res_first_rdy < 0) res_first_rdy = cyc;
            if (done === 1'b1) res_done_at = cyc;
            if (busy !== ((cyc > 0) ? 1'b1 : 1'b0)) res_busy_err++;
            if (stop_at > 0 && res_shifts == stop_at) break;
            start     = (cyc == 0) || (cyc == restart_at);
            abort     = (cyc == 0) && abort_with_start;
            cfg_valid = (res_hs < NB) || extra;
            if (cfg_valid && cfg_ready && res_hs > 0 && withheld < gap) begin
                cfg_valid = 1'b0;
                withheld++;
            end
            cfg_data = (res_hs < NB) ? stream[res_hs] : 8'hFF;
            if (cfg_valid && cfg_ready) begin
                res_hs++;
                withheld = 0;
            end
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int done_seen;
        int en_seen;

        pReset = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_valid = 1'b0; cfg_data = 8'h00;
        repeat (2) @(posedge prog_clk);
        #1;
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_ccff_head", ccff_head, 0);
        check("rst_prog_clk_en", prog_clk_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef CCFF_LOADER_READBACK_EN
        check("rst_rb_ones", rb_ones, 0);
`endif
        pReset = 1'b1;
        tick();
        tick();

        // A: 0xA5 back-to-back, stray start at cycle 50 must be ignored.
        foreach (stream[i]) stream[i] = 8'hA5;
        do_load(0, 1'b0, 50, 1'b0, 0);
        check("a_shifts", res_shifts, 585);
        check("a_head_bits", res_head_err, 0);
        check("a_done_at", res_done_at, 587);
        check("a_first_ready", res_first_rdy, 1);
        check("a_first_en", res_first_en, 2);
        check("a_handshakes", res_hs, 74);
        check("a_busy", res_busy_err, 0);
        check("a_done_pulse", done, 0);
        check("a_busy_after", busy, 0);

        // B: three withheld ready cycles after every byte.
        do_load(3, 1'b0, -1, 1'b0, 0);
        check("b_shifts", res_shifts, 585);
        check("b_head_bits", res_head_err, 0);
        check("b_gap_cycles", res_gap, 219);
        check("b_done_at", res_done_at, 806);

        // C: final byte 0xFF, and a 75th byte is kept on offer.
        foreach (stream[i]) stream[i] = 8'(i) ^ 8'h5A;
        stream[NB-1] = 8'hFF;
        do_load(0, 1'b1, -1, 1'b0, 0);
        check("c_shifts", res_shifts, 585);
        check("c_handshakes", res_hs, 74);
        check("c_head_bits", res_head_err, 0);
        check("c_done_at", res_done_at, 587);
        check("c_ready_idle", cfg_ready, 0);
        cfg_valid = 1'b0;
        tick();

        // D: abort after 100 shifts, then start+abort together restarts.
        foreach (stream[i]) stream[i] = 8'hC3;
        do_load(0, 1'b0, -1, 1'b0, 100);
        check("d_shifts_before", res_shifts, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cfg_valid = 1'b0;
        check("d_busy", busy, 0);
        check("d_prog_clk_en", prog_clk_en, 0);
        check("d_cfg_ready", cfg_ready, 0);
        done_seen = 0;
        en_seen = 0;
        repeat (600) begin
            if (done === 1'b1) done_seen++;
            if (prog_clk_en === 1'b1) en_seen++;
            tick();
        end
        check("d_no_done", done_seen, 0);
        check("d_no_shift", en_seen, 0);
        do_load(0, 1'b0, -1, 1'b1, 0);
        check("d2_shifts", res_shifts, 585);
        check("d2_done_at", res_done_at, 587);
        check("d2_head_bits", res_head_err, 0);

        // E: asynchronous reset at shift 300, head is 1 just before it.
        foreach (stream[i]) stream[i] = 8'hFF;
        do_load(0, 1'b0, -1, 1'b0, 300);
        check("e_head_before", ccff_head, 1);
        #2 pReset = 1'b0;
        #1;
        check("e_cfg_ready", cfg_ready, 0);
        check("e_ccff_head", ccff_head, 0);
        check("e_prog_clk_en", prog_clk_en, 0);
        check("e_busy", busy, 0);
        check("e_done", done, 0);
        tick();
        pReset = 1'b1;
        cfg_valid = 1'b0;
        tick();

`ifdef CCFF_LOADER_READBACK_EN
        // F: readback over an all-ones, then two all-zero loads.
        foreach (stream[i]) stream[i] = 8'hFF;
        do_load(0, 1'b0, -1, 1'b0, 0);
        check("f_rb_first", rb_ones, 0);
        foreach (stream[i]) stream[i] = 8'h00;
        do_load(0, 1'b0, -1, 1'b0, 0);
        check("f_rb_ones", rb_ones, 585);
        do_load(0, 1'b0, -1, 1'b0, 0);
        check("f_rb_zeros", rb_ones, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader for the CLB fabric. It accepts the bitstream as a byte stream over a valid/ready handshake and serializes it LSB-first onto `ccff_head` of the tile chain. It also produces the clock enable for the gated `prog_clk` that drives every `frac_lut6` memory stage. It sits between the bitstream host interface and the head of the chain (`NUM_TILES` × `CHAIN_LEN` DFFRX1 stages: 64 LUT SRAM bits + 1 mode bit per tile).

## Interface
- `CHAIN_LEN`, 65, config bits per tile (64 sram + mode)
- `NUM_TILES`, 9, tiles on the chain (3x3 fabric)
- `prog_clk`  in  1  programming clock; all logic on rising edge
- `pReset`  in  1  reset, asynchronous assert, active-low (0 = reset)
- `start`  in  1  single-cycle pulse; begins a load when idle
- `abort`  in  1  single-cycle pulse; cancels a load in progress
- `cfg_data`  in  8  bitstream byte, bit 0 shifted first
- `cfg_valid`  in  1  `cfg_data` valid
- `cfg_ready`  out  1  byte accepted when `cfg_valid && cfg_ready`
- `ccff_head`  out  1  serial bit into chain head
- `prog_clk_en`  out  1  enable for chain clock gate; chain shifts on the edge ending a cycle where it is 1
- `ccff_tail`  in  1  chain tail (readback only)
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle pulse when the final bit has been shifted

## Operation
- `TOTAL_BITS = CHAIN_LEN*NUM_TILES` (585 by default). `NBYTES = ceil(TOTAL_BITS/8)` (74). In the final byte, only bits `0..(TOTAL_BITS-1)%8` are used; the rest are discarded.
- States:
  - IDLE: `start` → LOAD; bit counter loaded with `TOTAL_BITS`; byte buffer empty.
  - LOAD: each cycle the buffer holds a bit, drive `ccff_head` = current bit and `prog_clk_en` = 1, then decrement the counter. When the counter reaches 0 on a shift, go to DONE.
  - DONE: assert `done` for one cycle → IDLE.
- Buffer empty in LOAD: `prog_clk_en` = 0 and `ccff_head` holds its last value; the chain does not move.
- `cfg_ready` = LOAD && (buffer empty || last valid bit of the buffer shifts this cycle) && bytes accepted < `NBYTES`. This gives back-to-back bytes with no bubble. Bytes offered outside LOAD are not accepted.
- `start` is ignored outside IDLE.
- `abort` in LOAD → IDLE next cycle. The buffer is flushed, no `done`, and the chain is left partially shifted. `abort` in IDLE or DONE has no effect.
- `abort` and `start` in the same cycle while IDLE: `start` wins.
- `pReset` asserted mid-load: immediate return to IDLE. The chain's own `pReset` clears it.

## Timing
- Reset values: `cfg_ready`=0, `ccff_head`=0, `prog_clk_en`=0, `busy`=0, `done`=0. Readback counter = 0.
- `busy` = 1 from the cycle after `start` through the DONE cycle.
- First byte acceptable the cycle after `start`. First `prog_clk_en` the cycle after the first handshake.
- Minimum load time with `cfg_valid` held high: `TOTAL_BITS` + 2 cycles from `start` to `done`. Default is 587.
- `ccff_head` and `prog_clk_en` are registered outputs with no combinational path from inputs. `cfg_ready` may depend on state only, not on `cfg_valid`.

## Configuration
- `CCFF_LOADER_READBACK_EN` defined:
  - Adds output `rb_ones` (width `$clog2(TOTAL_BITS+1)`), cleared on `start`.
  - It increments on every cycle with `prog_clk_en`=1 and `ccff_tail`=1, so after a load it equals the popcount of the previous configuration.
  - `ccff_tail` is sampled only under the macro.
- Undefined: `ccff_tail` is unused and `rb_ones` is absent.

## Structure
- Package `ccff_loader_pkg` contains:
  - the state enum (IDLE, LOAD, DONE);
  - functions `total_bits(chain_len, num_tiles)` and `nbytes(total)`;
  - the `CFG_BYTE_W = 8` constant.
- Sub-module `ccff_byte_serializer` contains the 8-bit buffer, valid-bit count, last-byte truncation and ready generation. The top level keeps the FSM, the bit counter and readback.

## Test plan
- Reset, then `start`, stream 74 bytes of 0xA5 with `cfg_valid` held high → exactly 585 `prog_clk_en` pulses, the `ccff_head` sequence 1,0,1,0,0,1,0,1 repeating, and `done` 587 cycles after `start`.
- Same stream with `cfg_valid` low for 3 cycles after every byte → still 585 shifts, no extra or lost bits, and `prog_clk_en`=0 during the gaps.
- Final byte 0xFF → only bit 0 is shifted. A 75th byte offered is never accepted (`cfg_ready`=0 after 74 handshakes).
- `abort` after 100 shifts → IDLE next cycle, `busy`=0, no `done`. A following `start` restarts the count at 585.
- `pReset` driven low at shift 300 → all outputs at reset values asynchronously, before the next clock edge.
- With `CCFF_LOADER_READBACK_EN`: load all-ones, then load all-zeros → `rb_ones` = 585 after the second load. A third load gives `rb_ones` = 0.
